// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine and the core top level.
package regfile_dump_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_REG_DEPTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready stream carrying one dumped register per beat.
interface regfile_dump_if
    import regfile_dump_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  dump_valid;
    logic                  dump_ready;
    logic [DATA_WIDTH-1:0] dump_data;
    logic [ADDR_WIDTH-1:0] dump_idx;
    logic                  dump_last;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_idx,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_idx,
        input  dump_last,
        output dump_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a register index range on a spare read port
// and streams each value out through a single registered output slot.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned REG_DEPTH  = DEF_REG_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_idx,
    input  logic [ADDR_WIDTH-1:0] last_idx,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    regfile_dump_if.master        dump,
    output logic                  busy,
    output logic                  done
);

    // The index range must be addressable, otherwise the walk could wrap.
    if (REG_DEPTH > (64'd1 << ADDR_WIDTH)) begin : g_depth_check
        $error("regfile_dump: REG_DEPTH does not fit in ADDR_WIDTH");
    end

    state_e                state;
    logic [ADDR_WIDTH-1:0] end_idx;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  last_q;

    logic slot_free_c;
    logic at_end_c;

    assign slot_free_c = !valid_q || dump.dump_ready;
    assign at_end_c    = (rf_addr == end_idx);

    // FSM and output slot; every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rf_addr <= '0;
            end_idx <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rf_addr <= first_idx;
                        // An inverted range collapses to the single first register.
                        end_idx <= (last_idx < first_idx) ? first_idx : last_idx;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (slot_free_c) begin
                        data_q  <= rf_data;
                        idx_q   <= rf_addr;
                        valid_q <= 1'b1;
                        last_q  <= at_end_c;
                        if (at_end_c) begin
                            state <= DRAIN;
                        end else begin
                            rf_addr <= rf_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (valid_q && dump.dump_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign dump.dump_valid = valid_q;
    assign dump.dump_data  = data_q;
    assign dump.dump_idx   = idx_q;
    assign dump.dump_last  = last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a queue of expected beats built from the
// register array and range rules, drained by an independent stream monitor.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    localparam int unsigned DW = DEF_DATA_WIDTH;
    localparam int unsigned AW = DEF_ADDR_WIDTH;
    localparam int unsigned RD = DEF_REG_DEPTH;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start;
    logic [AW-1:0] first_idx;
    logic [AW-1:0] last_idx;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          busy;
    logic          done;

    regfile_dump_if dif ();

    logic [DW-1:0] regs [RD];
    assign rf_data = regs[rf_addr];

    regfile_dump dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .dump      (dif),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q [$];
    exp_t held;
    exp_t popped;
    bit   hold_pending = 0;
    bit   done_due = 0;
    bit   prev_busy = 0;
    bit   fv_seen = 0;
    bit   fh_seen = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   st_cyc = 0;
    int   first_valid_cyc = 0;
    int   first_hs_cyc = 0;
    int   done_cyc = 0;
    int   ready_mode = 0;
    int   pat = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    always @(posedge clk) begin
        cyc++;
        #1;
        case (ready_mode)
            0:       dif.dump_ready = 1'b1;
            1: begin
                dif.dump_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
                pat++;
            end
            default: dif.dump_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard on each handshake, checks stall stability and done timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done || done_due) check("done_pulse", longint'(done), longint'(done_due));
            done_due = 0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_with_done", longint'(busy), 0);
                check("busy_before_done", longint'(prev_busy), 1);
            end
            if (dif.dump_valid) begin
                if (!fv_seen) begin
                    fv_seen = 1;
                    first_valid_cyc = cyc;
                end
                if (hold_pending) begin
                    check("stall_idx", longint'(dif.dump_idx), longint'(held.idx));
                    check("stall_data", longint'(dif.dump_data), longint'(held.data));
                    check("stall_last", longint'(dif.dump_last), longint'(held.last));
                end
                if (dif.dump_ready) begin
                    hold_pending = 0;
                    hs_cnt++;
                    if (!fh_seen) begin
                        fh_seen = 1;
                        first_hs_cyc = cyc;
                    end
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", longint'(dif.dump_idx), -1);
                    end else begin
                        popped = exp_q.pop_front();
                        check("beat_idx", longint'(dif.dump_idx), longint'(popped.idx));
                        check("beat_data", longint'(dif.dump_data), longint'(popped.data));
                        check("beat_last", longint'(dif.dump_last), longint'(popped.last));
                        done_due = popped.last;
                    end
                end else begin
                    hold_pending = 1;
                    held.idx  = int'(dif.dump_idx);
                    held.data = dif.dump_data;
                    held.last = dif.dump_last;
                end
            end
            prev_busy = busy;
        end
    end

    // Reference: the beats a dump of [f..l] must produce, from the current register contents.
    task automatic push_dump(input int f, input int l);
        int en;
        en = (l < f) ? f : l;
        for (int i = f; i <= en; i++) exp_q.push_back('{i, regs[i], (i == en)});
    endtask

    task automatic do_start(input int f, input int l);
        @(posedge clk);
        #2;
        first_idx = AW'(f);
        last_idx  = AW'(l);
        start     = 1'b1;
        fv_seen   = 0;
        fh_seen   = 0;
        push_dump(f, l);
        @(posedge clk);
        #2;
        start  = 1'b0;
        st_cyc = cyc;
    endtask

    task automatic wait_done(input int max_cyc, input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_timeout", longint'(done_cnt >= target), 1);
    endtask

    int hs_base;
    int dn_base;
    int n;

    initial begin
        start = 1'b0;
        first_idx = '0;
        last_idx = '0;
        dif.dump_ready = 1'b0;
        for (int i = 0; i < RD; i++) regs[i] = DW'(32'h1000 + i);
        #1 rst_n = 1'b0;
        #11;
        check("rst_rf_addr", longint'(rf_addr), 0);
        check("rst_valid", longint'(dif.dump_valid), 0);
        check("rst_data", longint'(dif.dump_data), 0);
        check("rst_idx", longint'(dif.dump_idx), 0);
        check("rst_last", longint'(dif.dump_last), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full range with the consumer always ready.
        ready_mode = 0;
        hs_base = hs_cnt;
        do_start(0, 31);
        wait_done(100, 1);
        check("full_hs", hs_cnt - hs_base, 32);
        check("full_latency", first_valid_cyc - st_cyc, 1);
        check("full_throughput", done_cyc - first_hs_cyc, 32);
        check("full_q_empty", exp_q.size(), 0);

        // Backpressure with a fixed stall pattern.
        for (int i = 0; i < RD; i++) regs[i] = $urandom();
        ready_mode = 1;
        pat = 0;
        hs_base = hs_cnt;
        do_start(4, 7);
        wait_done(100, 2);
        check("bp_hs", hs_cnt - hs_base, 4);
        check("bp_q_empty", exp_q.size(), 0);

        // Inverted range dumps only the first register.
        ready_mode = 2;
        hs_base = hs_cnt;
        do_start(9, 3);
        wait_done(100, 3);
        check("inv_hs", hs_cnt - hs_base, 1);
        check("inv_q_empty", exp_q.size(), 0);

        // Top register: no wrap of the read address.
        hs_base = hs_cnt;
        do_start(31, 31);
        wait_done(100, 4);
        repeat (2) @(negedge clk);
        check("top_hs", hs_cnt - hs_base, 1);
        check("top_rf_addr", longint'(rf_addr), 31);
        check("top_idle", longint'(busy), 0);

        // start held from mid-dump through the completing edge must be ignored.
        ready_mode = 0;
        hs_base = hs_cnt;
        dn_base = done_cnt;
        do_start(0, 15);
        repeat (3) @(negedge clk);
        #1;
        first_idx = AW'(20);
        last_idx  = AW'(25);
        start     = 1'b1;
        n = 0;
        while (done_cnt == dn_base && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check("busy_start_done", done_cnt - dn_base, 1);
        repeat (6) @(negedge clk);
        check("busy_start_hs", hs_cnt - hs_base, 16);
        check("busy_start_idle", longint'(busy), 0);
        check("busy_start_q_empty", exp_q.size(), 0);

        // Reset in the middle of a dump.
        hs_base = hs_cnt;
        dn_base = done_cnt;
        do_start(0, 31);
        n = 0;
        while (hs_cnt - hs_base < 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_rst_reached", hs_cnt - hs_base, 5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", longint'(dif.dump_valid), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_done", longint'(done), 0);
        exp_q.delete();
        hold_pending = 0;
        done_due = 0;
        prev_busy = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_no_done", done_cnt - dn_base, 0);
        hs_base = hs_cnt;
        do_start(0, 2);
        wait_done(100, dn_base + 1);
        check("post_rst_hs", hs_cnt - hs_base, 3);
        check("post_rst_q_empty", exp_q.size(), 0);

        // Random ranges, contents and consumer behaviour.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < RD; i++) regs[i] = $urandom();
            ready_mode = int'($urandom_range(0, 2));
            pat = 0;
            dn_base = done_cnt;
            do_start(int'($urandom_range(0, RD - 1)), int'($urandom_range(0, RD - 1)));
            wait_done(400, dn_base + 1);
            check("rand_q_empty", exp_q.size(), 0);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
